// File: rtl/brg_xcel_mem_responder.sv
// brg_xcel_mem_responder
//   Memory-side responder for the BRG accelerator master interface. Accepts
//   load/store requests into a word-addressed local memory and returns one
//   valid-only response per load after a fixed latency, in accept order.
//
// Ports
//   clk_i, reset_n_i          clock, synchronous active-low reset
//   req_v_i / req_ready_o     request handshake (accept on v && ready)
//   req_type_i                1 = store, 0 = load
//   req_addr_i                byte address, bits [1:0] ignored
//   req_data_i, req_mask_i    store data and byte enables
//   req_opq_i                 opaque load id, echoed on the response
//   ret_v_o, ret_data_o,      load response (consumer always ready)
//   ret_opq_o
//   out_cnt_o                 outstanding loads
//   err_o                     sticky out-of-range flag
module brg_xcel_mem_responder #(
  parameter int data_width_p    = 32,
  parameter int addr_width_p    = 32,
  parameter int load_id_width_p = 11,
  parameter int mem_words_p     = 1024,
  parameter int latency_p       = 2,
  parameter int max_out_p       = 4
) (
  input  logic                               clk_i,
  input  logic                               reset_n_i,
  input  logic                               req_v_i,
  input  logic                               req_type_i,
  input  logic [addr_width_p-1:0]            req_addr_i,
  input  logic [data_width_p-1:0]            req_data_i,
  input  logic [data_width_p/8-1:0]          req_mask_i,
  input  logic [load_id_width_p-1:0]         req_opq_i,
  output logic                               req_ready_o,
  output logic                               ret_v_o,
  output logic [data_width_p-1:0]            ret_data_o,
  output logic [load_id_width_p-1:0]         ret_opq_o,
  output logic [$clog2(max_out_p+1)-1:0]     out_cnt_o,
  output logic                               err_o
);
  localparam int idx_w_lp  = $clog2(mem_words_p);
  localparam int cnt_w_lp  = $clog2(max_out_p+1);
  localparam int mask_w_lp = data_width_p/8;
  localparam logic [63:0] mem_bytes_lp = 64'(mem_words_p) << 2;

  typedef struct packed {
    logic [load_id_width_p-1:0] opq;
    logic [data_width_p-1:0]    data;
  } ret_s;

  logic [data_width_p-1:0] mem_r [mem_words_p];

  logic [idx_w_lp-1:0] idx;
  logic                in_range, accept, ld_acc, st_acc;
  ret_s                ld_ent;
  logic [cnt_w_lp-1:0] out_cnt_r;
  logic                err_r;

  // Stage latency_p-1 is the output stage; index 0 of the *_in vectors is
  // the entry being accepted this cycle.
  logic [latency_p-1:0] vld_pipe;
  ret_s [latency_p-1:0] ret_pipe;
  logic [latency_p:0]   vld_in;
  ret_s [latency_p:0]   ret_in;

  assign idx      = req_addr_i[2 +: idx_w_lp];
  assign in_range = 64'(req_addr_i) < mem_bytes_lp;

  // A retiring response frees its credit in the same cycle, so a full
  // counter does not cost a bubble.
  assign req_ready_o = reset_n_i && ((out_cnt_r < cnt_w_lp'(max_out_p)) || ret_v_o);
  assign accept      = req_v_i && req_ready_o;
  assign ld_acc      = accept && !req_type_i;
  assign st_acc      = accept &&  req_type_i;

  assign ld_ent.data = in_range ? mem_r[idx] : data_width_p'(32'hDEADBEEF);
  assign ld_ent.opq  = req_opq_i;

  assign vld_in = {vld_pipe, ld_acc};
  assign ret_in = {ret_pipe, ld_ent};

  // Memory is deliberately not reset.
  always_ff @(posedge clk_i) begin
    if (st_acc && in_range) begin
      for (int b = 0; b < mask_w_lp; b++) begin
        if (req_mask_i[b]) mem_r[idx][8*b +: 8] <= req_data_i[8*b +: 8];
      end
    end
  end

  // Payload only moves with a valid so the output holds its last response.
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      vld_pipe <= '0;
      ret_pipe <= '0;
    end else begin
      vld_pipe <= vld_in[latency_p-1:0];
      for (int k = 0; k < latency_p; k++) begin
        if (vld_in[k]) ret_pipe[k] <= ret_in[k];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      out_cnt_r <= '0;
      err_r     <= 1'b0;
    end else begin
      if (ld_acc && !ret_v_o)      out_cnt_r <= out_cnt_r + cnt_w_lp'(1);
      else if (!ld_acc && ret_v_o) out_cnt_r <= out_cnt_r - cnt_w_lp'(1);
      if (accept && !in_range) err_r <= 1'b1;
    end
  end

  assign ret_v_o    = vld_pipe[latency_p-1];
  assign ret_data_o = ret_pipe[latency_p-1].data;
  assign ret_opq_o  = ret_pipe[latency_p-1].opq;
  assign out_cnt_o  = out_cnt_r;
  assign err_o      = err_r;
endmodule

// File: doc/brg_xcel_mem_responder.md
# brg_xcel_mem_responder

Memory-side responder for the BRG accelerator master interface. It accepts the accelerator's master requests (valid/ready, type, byte address, data, mask, opaque id) into a word-addressed local memory. Each accepted load returns one valid-only response after a fixed latency, with the data and the echoed opaque id. Used as a standalone memory model so streaming accelerators can be unit-tested without the manycore endpoint and packet encoder.

## Interface
- data_width_p, 32: word width; must be a multiple of 8.
- addr_width_p, 32: byte-address width.
- load_id_width_p, 11: opaque id width.
- mem_words_p, 1024: memory depth in words; must be a power of 2.
- latency_p, 2: cycles from load accept to response; must be ≥1.
- max_out_p, 4: maximum number of outstanding loads; must be ≥1.
- clk_i  in  1  clock; all state updates on the rising edge.
- reset_n_i  in  1  synchronous, active-low reset.
- req_v_i  in  1  request valid.
- req_type_i  in  1  request type: 1 = store, 0 = load.
- req_addr_i  in  addr_width_p  byte address; bits [1:0] are ignored.
- req_data_i  in  data_width_p  store data.
- req_mask_i  in  data_width_p/8  byte enables for stores; ignored for loads.
- req_opq_i  in  load_id_width_p  opaque id; meaningful for loads only.
- req_ready_o  out  1  request ready.
- ret_v_o  out  1  response valid; the consumer is always ready, so there is no ret ready.
- ret_data_o  out  data_width_p  load data.
- ret_opq_o  out  load_id_width_p  echoed opaque id.
- out_cnt_o  out  $clog2(max_out_p+1)  number of outstanding loads.
- err_o  out  1  sticky out-of-range flag.

## Operation
- **Accept.** A request is accepted on a rising edge where req_v_i && req_ready_o. At most one request is accepted per cycle.
- **Word index.** idx = req_addr_i[2 +: $clog2(mem_words_p)].
- **Range check.** An address is in range iff req_addr_i < mem_words_p*4.
- **Store (in range).** Write byte lane b iff req_mask_i[b]. The write takes effect at the accept edge. A store produces no response and does not consume credit.
- **Load.** Read mem[idx] at the accept edge. If out of range, the data is 32'hDEADBEEF, zero-extended or truncated to data_width_p. The data and opq enter stage 0 of a latency_p-deep valid/data/opq shift pipeline. The last stage drives ret_v_o, ret_data_o and ret_opq_o.
- **Ordering.**
  - Responses return in accept order, at most one per cycle, with no gaps introduced by the block.
  - A load accepted the cycle after a store to the same word returns the newly stored data.
- **Out of range.**
  - A store is dropped.
  - Either request type sets err_o at the accept edge. err_o stays set until reset.
- **Credit counter out_cnt_r.**
  - +1 on load accept.
  - −1 when ret_v_o is high.
  - Unchanged when both happen in the same cycle.
  - Never exceeds max_out_p and never underflows.
- **Ready.** req_ready_o = reset_n_i && ((out_cnt_r < max_out_p) || ret_v_o).
  - Stores are gated by the same ready signal; ready does not depend on req_v_i or req_type_i.
- **Reset.** While reset_n_i is low at an edge:
  - Pipeline valids clear, out_cnt_r = 0, err_o = 0.
  - In-flight loads are discarded and never respond.
  - Memory contents are not reset.
  - Requests presented during reset are not accepted, because req_ready_o = 0.

## Timing
- **Output reset values.** ret_v_o = 0, ret_data_o = 0, ret_opq_o = 0, out_cnt_o = 0, err_o = 0, req_ready_o = 0.
- **Load latency.** A load accepted at edge t drives ret_v_o high for exactly the one cycle following edge t+latency_p−1.
  - With latency_p = 1, the response is visible in the cycle right after the accept edge.
- **Throughput.** Full throughput of one load per cycle is sustained iff max_out_p ≥ latency_p. Otherwise ready drops once max_out_p loads are outstanding.
- **Same-cycle accept and retire.** When the counter is at the limit, a response retiring in the current cycle re-opens ready in that same cycle, so the counter holds at max_out_p.
- **Output stability.** ret_data_o and ret_opq_o are registered. They hold their last values when ret_v_o = 0.
- **Counter visibility.** out_cnt_o is registered and reflects all accepts and retires up to the previous edge.

## Test plan
- **Store then load.** Store 0x12345678 to addr 0x10 with mask 4'hF. Next cycle, load addr 0x10 with opq 5. Required: ret_v_o for one cycle, latency_p cycles after the load accept, carrying data 0x12345678 and opq 5.
- **Masked store.** Store 0xFFFFFFFF, then store 0xAABBCCDD with mask 4'b0101, then load the same word. Required: data 0xFFBBFFDD.
- **Streaming loads.** With max_out_p=4 and latency_p=2, issue 8 back-to-back loads to words 0..7, which were preloaded with their index, using opq = index. Required:
  - req_ready_o stays 1 throughout.
  - 8 consecutive ret_v_o cycles with data/opq pairs 0..7 in order.
  - out_cnt_o peaks at 2.
- **Credit limit.** With max_out_p=1 and latency_p=3, hold req_v_i high for loads. Required:
  - After each accept, ready = 0 until the response cycle, and ready rises in that response cycle.
  - One accept every 3 cycles.
  - out_cnt_o never exceeds 1.
- **Out of range.** With mem_words_p=1024, load addr 0x1000 with opq 9, then store to 0x2000. Required:
  - Load response data is 0xDEADBEEF with opq 9.
  - err_o = 1 from the edge after the load accept and stays 1.
  - Memory is unchanged, verified by re-reading words 0 and 1023.
- **Reset mid-flight.** With latency_p=3, accept 2 loads, then drive reset_n_i = 0 for one edge. Required:
  - No ret_v_o ever appears for either load.
  - out_cnt_o = 0 and err_o = 0.
  - A new load after reset responds normally with the stored data.
